// File: rtl/snake_engine_if.sv
// Pixel stream from the snake engine to the renderer: valid/ready handshake
// carrying one screen coordinate plus head/food tags per transfer.
interface snake_engine_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] rx;
    logic [8:0] ry;
    logic       pix_head;
    logic       pix_food;

    modport master (output pix_valid, rx, ry, pix_head, pix_food, input pix_ready);
    modport slave  (input pix_valid, rx, ry, pix_head, pix_food, output pix_ready);
endinterface

// File: rtl/snake_engine.sv
// Snake body engine: ring buffer of grid cells, one move per step pulse with
// growth, wrap/edge death and self-collision, plus a pixel scan for rendering.
module snake_engine #(
    parameter int MAX_LEN  = 64,
    parameter int COLS     = 64,
    parameter int ROWS     = 48,
    parameter int CELL     = 10,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 1,
    localparam int CW      = $clog2(COLS),
    localparam int RW      = $clog2(ROWS),
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic                 draw_clk,
    input  logic                 reset,
    input  logic                 step,
    input  logic [1:0]           direction,
    input  logic [CW-1:0]        food_x,
    input  logic [RW-1:0]        food_y,
    input  logic                 draw_start,
    snake_engine_if.master       pix,
    output logic                 draw_done,
    output logic                 ate,
    output logic                 dead,
    output logic [LW-1:0]        length,
    output logic                 busy
);

    localparam int PW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {IDLE, MOVE, CHECK, SCAN, DONE, DEAD} state_t;

    state_t        state;
    logic [CW-1:0] seg_x [MAX_LEN];
    logic [RW-1:0] seg_y [MAX_LEN];
    logic [PW-1:0] head_ptr;
    logic [1:0]    heading;
    logic [LW-1:0] idx;

    logic [PW-1:0] idx_ptr;
    logic [CW-1:0] cur_x, next_x;
    logic [RW-1:0] cur_y, next_y;
    logic [1:0]    eff_dir;
    logic          off_grid;
    logic          food_hit;

    function automatic logic [9:0] col_px(input logic [CW-1:0] c);
        return 10'(32'(c) * CELL);
    endfunction

    function automatic logic [8:0] row_px(input logic [RW-1:0] r);
        return 9'(32'(r) * CELL);
    endfunction

    // idx is the segment number shared by the collision walk and the scan
    assign idx_ptr = head_ptr - idx[PW-1:0];

    always_comb begin
        cur_x    = seg_x[head_ptr];
        cur_y    = seg_y[head_ptr];
        eff_dir  = (direction == (heading ^ 2'b10)) ? heading : direction;
        next_x   = cur_x;
        next_y   = cur_y;
        off_grid = 1'b0;
        case (eff_dir)
            2'b00: if (cur_y == '0) begin
                       next_y   = RW'(ROWS - 1);
                       off_grid = 1'b1;
                   end else next_y = cur_y - RW'(1);
            2'b01: if (cur_x == CW'(COLS - 1)) begin
                       next_x   = '0;
                       off_grid = 1'b1;
                   end else next_x = cur_x + CW'(1);
            2'b10: if (cur_y == RW'(ROWS - 1)) begin
                       next_y   = '0;
                       off_grid = 1'b1;
                   end else next_y = cur_y + RW'(1);
            default: if (cur_x == '0) begin
                       next_x   = CW'(COLS - 1);
                       off_grid = 1'b1;
                   end else next_x = cur_x - CW'(1);
        endcase
        food_hit = (next_x == food_x) && (next_y == food_y);
    end

    always_ff @(posedge draw_clk) begin
        if (!reset) begin
            state         <= IDLE;
            head_ptr      <= '0;
            heading       <= 2'b01;
            length        <= LW'(INIT_LEN);
            idx           <= '0;
            pix.pix_valid <= 1'b0;
            pix.rx        <= '0;
            pix.ry        <= '0;
            pix.pix_head  <= 1'b0;
            pix.pix_food  <= 1'b0;
            draw_done     <= 1'b0;
            ate           <= 1'b0;
            dead          <= 1'b0;
            busy          <= 1'b0;
            // Segment k sits at index (0 - k) mod MAX_LEN, lined up left of centre
            for (int i = 0; i < MAX_LEN; i++) begin
                if (((MAX_LEN - i) % MAX_LEN) < INIT_LEN) begin
                    seg_x[i] <= CW'(COLS / 2 - (MAX_LEN - i) % MAX_LEN);
                    seg_y[i] <= RW'(ROWS / 2);
                end else begin
                    seg_x[i] <= '0;
                    seg_y[i] <= '0;
                end
            end
        end else begin
            ate       <= 1'b0;
            draw_done <= 1'b0;
            case (state)
                IDLE, DEAD: begin
                    if (state == IDLE && step) begin
                        state <= MOVE;
                        busy  <= 1'b1;
                    end else if (draw_start) begin
                        pix.pix_valid <= 1'b1;
                        pix.rx        <= col_px(cur_x);
                        pix.ry        <= row_px(cur_y);
                        pix.pix_head  <= 1'b1;
                        pix.pix_food  <= 1'b0;
                        idx           <= LW'(1);
                        state         <= SCAN;
                        busy          <= 1'b1;
                    end
                end
                MOVE: begin
                    heading <= eff_dir;
                    if (off_grid && WRAP == 0) begin
                        dead  <= 1'b1;
                        state <= DEAD;
                        busy  <= 1'b0;
                    end else begin
                        head_ptr                  <= head_ptr + PW'(1);
                        seg_x[head_ptr + PW'(1)]  <= next_x;
                        seg_y[head_ptr + PW'(1)]  <= next_y;
                        if (food_hit) begin
                            ate <= 1'b1;
                            if (length != LW'(MAX_LEN))
                                length <= length + LW'(1);
                        end
                        idx   <= LW'(1);
                        state <= CHECK;
                    end
                end
                // Walks segments 1..length-1; the dropped tail is never visited
                CHECK: begin
                    if (seg_x[idx_ptr] == cur_x && seg_y[idx_ptr] == cur_y) begin
                        dead  <= 1'b1;
                        state <= DEAD;
                        busy  <= 1'b0;
                    end else if (idx == length - LW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + LW'(1);
                    end
                end
                SCAN: begin
                    if (pix.pix_ready) begin
                        if (pix.pix_food) begin
                            pix.pix_valid <= 1'b0;
                            pix.pix_food  <= 1'b0;
                            draw_done     <= 1'b1;
                            state         <= DONE;
                        end else if (idx == length) begin
                            pix.rx       <= col_px(food_x);
                            pix.ry       <= row_px(food_y);
                            pix.pix_head <= 1'b0;
                            pix.pix_food <= 1'b1;
                        end else begin
                            pix.rx       <= col_px(seg_x[idx_ptr]);
                            pix.ry       <= row_px(seg_y[idx_ptr]);
                            pix.pix_head <= 1'b0;
                            idx          <= idx + LW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= dead ? DEAD : IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
